// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3-256 sponge controller.
//   LANE_W / RATE_LANES / DIGEST_W / STATE_W : sponge geometry
//   PAD_DS / PAD_END                         : SHA3 domain-separation and final pad bytes
//   state_e                                  : controller FSM states
package sha3_pkg;

  localparam int LANE_W     = 64;
  localparam int RATE_LANES = 17;
  localparam int DIGEST_W   = 256;
  localparam int STATE_W    = 1600;

  localparam logic [7:0] PAD_DS  = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  // Bit position of byte 7 of the last rate lane, where PAD_END is folded in.
  localparam int END_POS = (RATE_LANES - 1) * LANE_W + LANE_W - 8;

  typedef enum logic [2:0] {
    ABSORB,
    PAD,
    PERM,
    WAIT,
    SQUEEZE
  } state_e;

endpackage

// File: rtl/sha3_pad_lane.sv
// Combinational lane padder.
//   data_i  : raw message lane (byte j at [8j+7:8j])
//   bytes_i : valid bytes in the lane, already clamped to 0..8
//   last_i  : lane is the final lane of the message
//   lane_o  : lane to XOR into the state; on a short final lane the bytes at
//             and above bytes_i are zeroed and PAD_DS is placed at byte bytes_i
module sha3_pad_lane
  import sha3_pkg::*;
(
  input  logic [LANE_W-1:0] data_i,
  input  logic [3:0]        bytes_i,
  input  logic              last_i,
  output logic [LANE_W-1:0] lane_o
);

  always_comb begin
    lane_o = data_i;
    if (last_i && (bytes_i < 4'd8)) begin
      for (int j = 0; j < 8; j++) begin
        if (j >= int'(bytes_i)) lane_o[8*j +: 8] = 8'h00;
        if (j == int'(bytes_i)) lane_o[8*j +: 8] = PAD_DS;
      end
    end
  end

endmodule

// File: rtl/sha3_sponge_ctrl.sv
// SHA3-256 sponge controller sitting in front of a keccak-f[1600] core.
//   msg_*        : 64-bit message lanes in (valid/ready), msg_last/msg_bytes close a message
//   perm_*       : start pulse and state out to the core, permuted state and done back
//   digest_*     : 256-bit digest out (valid/ready), byte 0 of the hash at [7:0]
//   busy         : a message is in progress
//
// state   | meaning
// ABSORB  | accepting lanes, XOR into lane L of S
// PAD     | one cycle: fold the standalone pad block (0x06 .. 0x80) into S
// PERM    | one cycle: pulse perm_start with S on perm_state_o
// WAIT    | waiting for perm_done, then load the permuted state
// SQUEEZE | digest held on the output until the consumer accepts
module sha3_sponge_ctrl
  import sha3_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [LANE_W-1:0]   msg_data,
  input  logic                msg_last,
  input  logic [3:0]          msg_bytes,
  output logic                perm_start,
  output logic [STATE_W-1:0]  perm_state_o,
  input  logic [STATE_W-1:0]  perm_state_i,
  input  logic                perm_done,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                busy
);

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  state_e             state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [4:0]         l_q, l_d;
  logic               final_q, final_d;
  logic               pad_pend_q, pad_pend_d;
  logic               perm_start_q, perm_start_d;
  logic               digest_valid_q, digest_valid_d;
  logic               msg_ready_q, msg_ready_d;
  logic               busy_q, busy_d;

  logic [3:0]         bytes_eff;
  logic [10:0]        lane_base;
  logic [LANE_W-1:0]  pad_lane;

  assign bytes_eff = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
  assign lane_base = {l_q, 6'd0};

  sha3_pad_lane u_pad_lane (
    .data_i  (msg_data),
    .bytes_i (bytes_eff),
    .last_i  (msg_last),
    .lane_o  (pad_lane)
  );

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    l_d        = l_q;
    final_d    = final_q;
    pad_pend_d = pad_pend_q;

    case (state_q)
      ABSORB: begin
        if (msg_valid && msg_ready_q) begin
          s_d[lane_base +: LANE_W] = s_q[lane_base +: LANE_W] ^ pad_lane;
          if (msg_last && (bytes_eff != 4'd8)) begin
            // Short final lane: 0x06 already placed by the padder; when L is the
            // last lane and bytes==7 the two pad bytes coincide and give 0x86.
            s_d[END_POS +: 8] = s_d[END_POS +: 8] ^ PAD_END;
            final_d = 1'b1;
            state_d = PERM;
          end else if (l_q == LAST_LANE) begin
            // Block full; a full final lane here needs an extra all-pad block.
            l_d        = '0;
            final_d    = 1'b0;
            pad_pend_d = msg_last;
            state_d    = PERM;
          end else begin
            l_d = l_q + 5'd1;
            if (msg_last) state_d = PAD;
          end
        end
      end
      PAD: begin
        s_d[lane_base +: 8] = s_q[lane_base +: 8] ^ PAD_DS;
        s_d[END_POS +: 8]   = s_q[END_POS +: 8] ^ PAD_END;
        final_d = 1'b1;
        state_d = PERM;
      end
      PERM: state_d = WAIT;
      WAIT: begin
        if (perm_done) begin
          s_d = perm_state_i;
          if (final_q) begin
            state_d = SQUEEZE;
          end else if (pad_pend_q) begin
            l_d        = '0;
            pad_pend_d = 1'b0;
            state_d    = PAD;
          end else begin
            state_d = ABSORB;
          end
        end
      end
      SQUEEZE: begin
        if (digest_ready) begin
          s_d     = '0;
          l_d     = '0;
          final_d = 1'b0;
          state_d = ABSORB;
        end
      end
      default: state_d = ABSORB;
    endcase

    perm_start_d   = (state_d == PERM);
    digest_valid_d = (state_d == SQUEEZE);
    msg_ready_d    = (state_d == ABSORB);
    busy_d         = (state_d != ABSORB) || (l_d != 5'd0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ABSORB;
      s_q            <= '0;
      l_q            <= '0;
      final_q        <= 1'b0;
      pad_pend_q     <= 1'b0;
      perm_start_q   <= 1'b0;
      digest_valid_q <= 1'b0;
      msg_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      l_q            <= l_d;
      final_q        <= final_d;
      pad_pend_q     <= pad_pend_d;
      perm_start_q   <= perm_start_d;
      digest_valid_q <= digest_valid_d;
      msg_ready_q    <= msg_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign msg_ready    = msg_ready_q;
  assign perm_start   = perm_start_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;
  assign perm_state_o = s_q;
  assign digest       = s_q[DIGEST_W-1:0];

endmodule
